// File: rtl/stump_mem_pkg.sv
// Shared types and defaults for the Stump memory-port arbiter.
// Holds the access-sequencing state enum, owner encoding and a counter-width helper.
package stump_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stump_arb_pick.sv
// Winner select for the shared memory port: fixed CPU priority, with DMA forced
// through once the CPU has won STARVE_LIM contended arbitrations in a row.
module stump_arb_pick
    import stump_mem_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic grant_dma
);

    localparam int CW = bits_for(STARVE_LIM);

    logic [CW-1:0] starve_cnt;
    logic          at_lim;

    assign at_lim    = (starve_cnt == CW'(STARVE_LIM));
    assign grant_dma = dma_req & (~cpu_req | at_lim);

    // Counts only CPU wins that made a waiting DMA lose; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (grant_dma)
                starve_cnt <= '0;
            else if (dma_req && !at_lim)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stump_mem_arbiter.sv
// Shares the single Stump memory port between the CPU and a DMA/debug master.
// One access at a time: IDLE (arbitrate) -> ISSUE (strobe) -> WAIT (MEM_LAT) -> DONE (ack).
module stump_mem_arbiter
    import stump_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wen,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int LAT_W = bits_for(MEM_LAT - 1);

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    arb_state_e        state, state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    mem_req_t          cpu_side, dma_side, req_q;
    logic              owner_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              grant_en, grant_dma;
    logic              last_wait;

    assign cpu_side = '{wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_side = '{wen: dma_wen, addr: dma_addr, wdata: dma_wdata};

    assign grant_en  = (state == IDLE) & (cpu_req | dma_req);
    assign last_wait = (state == WAIT) & (lat_cnt == '0);

    stump_arb_pick #(
        .STARVE_LIM(STARVE_LIM)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .grant_en (grant_en),
        .grant_dma(grant_dma)
    );

    always_comb begin
        state_nxt = state;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_en)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_ren   = ~req_q.wen;
                mem_wen   = req_q.wen;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                cpu_ack   = (owner_q == OWN_CPU);
                dma_ack   = (owner_q == OWN_DMA);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            req_q       <= '0;
            owner_q     <= OWN_CPU;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            // Payload is frozen at grant; later changes by the requester are ignored.
            if (grant_en) begin
                owner_q <= grant_dma ? OWN_DMA : OWN_CPU;
                req_q   <= grant_dma ? dma_side : cpu_side;
            end
            if (state == ISSUE)
                lat_cnt <= LAT_W'(MEM_LAT - 1);
            else if (state == WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            // Writes leave the owner's read register untouched.
            if (last_wait && !req_q.wen) begin
                if (owner_q == OWN_DMA)
                    dma_rdata_q <= mem_rdata;
                else
                    cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign owner     = owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
